// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and default width for serial_subtractor
package serial_subtractor_pkg;
  localparam int SUB_DEFAULT_WIDTH = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational one-bit subtractor cell
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> d (difference bit), bout (borrow out)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full_subtractor cell, valid/ready in and out
// Ports: clk, rst_n (async, active low); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with results diff, borrow_out (a < b); busy (not IDLE).
// Macro SERIAL_SUBTRACTOR_SAT_EN: when defined, diff reads 0 in DONE if the result borrowed.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, diff_sh_q, diff_sh_d;
  logic borrow_q, borrow_d;
  logic cell_d, cell_bout;
  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    borrow_d  = borrow_q;
    if (state_q == IDLE && in_valid) begin
      state_d  = RUN;
      a_sh_d   = a;
      b_sh_d   = b;
      borrow_d = 1'b0;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      // result bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts
      diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
      a_sh_d    = a_sh_q >> 1;
      b_sh_d    = b_sh_q >> 1;
      borrow_d  = cell_bout;
      cnt_d     = cnt_q + 1'b1;
      state_d   = (cnt_q == CW'(WIDTH-1)) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      borrow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      borrow_q  <= borrow_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
  assign diff = (out_valid && borrow_q) ? '0 : diff_sh_q;
`else
  assign diff = diff_sh_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid, in_ready, out_valid, out_ready, borrow_out, busy;
  logic [3:0] a, b, diff;
  logic in_valid8, in_ready8, out_valid8, out_ready8, borrow_out8, busy8;
  logic [7:0] a8, b8, diff8;
  int checks = 0;
  int errors = 0;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out), .busy(busy)
  );
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8), .borrow_out(borrow_out8), .busy(busy8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_diff(input int x, input int y, input int w);
    int r;
    r = (x - y) & ((1 << w) - 1);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (x < y) r = 0;
`endif
    return r;
  endfunction
  task automatic do_op(input int x, input int y, input int hold);
    int n;
    logic [31:0] ed;
    ed = ref_diff(x, y, 4);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    in_valid = 1'b1; a = 4'(x); b = 4'(y);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom);
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 4);
    chk("diff", diff, ed);
    chk("borrow", borrow_out, 32'(x < y));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", diff, ed);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_one_cycle", out_valid, 0);
    chk("ready_after", in_ready, 1);
    out_ready = 1'b0;
  endtask
  task automatic do_op8(input int x, input int y);
    int n;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; a8 = 8'(x); b8 = 8'(y);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!out_valid8 && n < 30) begin @(posedge clk); #1; n++; end
    chk("latency8", n, 8);
    chk("diff8", diff8, ref_diff(x, y, 8));
    chk("borrow8", borrow_out8, 32'(x < y));
    @(posedge clk); #1;
    chk("valid8_one_cycle", out_valid8, 0);
    chk("ready8_after", in_ready8, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    in_valid = 0; out_ready = 0; a = 0; b = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(9, 3, 0);
    do_op(3, 9, 0);
    do_op(0, 15, 1);
    do_op(15, 15, 0);
    do_op(0, 0, 2);
    do_op(7, 12, 5);
    in_valid = 1'b1; a = 4'd11; b = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_in_ready", in_ready, 1);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_diff", diff, 0);
    chk("midrun_borrow", borrow_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(5, 2, 0);
    for (int k = 0; k < 20; k++) do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    do_op8(200, 55);
    do_op8(55, 200);
    for (int k = 0; k < 5; k++) do_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial borrow-ripple subtractor computing `a - b` one bit per clock, LSB first, using a single one-bit full subtractor cell. It is the subtracting counterpart of the team's ripple-carry adder. It trades latency for area in datapaths that already serialise arithmetic. Operands enter and results leave through valid/ready handshakes, so it can sit between any two handshaked stages.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2–32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset: asynchronous assert, active low.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  WIDTH  minuend, unsigned.
- `b`  in  WIDTH  subtrahend, unsigned.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `a - b` modulo 2^WIDTH (saturation variant: see Configuration).
- `borrow_out`  out  1  set when `a < b` (final borrow).
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding comes from the package.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready` at an edge: load the `a` and `b` shift registers, clear the borrow register, clear the bit counter, go to RUN.
- **RUN**
  - Each cycle the cell takes `a_sh[0]`, `b_sh[0]` and `borrow`.
  - Cell equations: `d = a^b^bin`, `bout = (~a&b) | (~(a^b)&bin)`.
  - On each edge: `d` shifts into the MSB of `diff_sh`; both operand registers shift right; `borrow` is updated; the counter increments.
  - When the counter reaches WIDTH-1 at an edge, the FSM goes to DONE at that edge.
- **DONE**
  - `out_valid`=1.
  - `diff` and `borrow_out` are driven from registers and stay stable until the handshake.
  - On `out_valid && out_ready` at an edge: go to IDLE.
- No overlap between operations: `in_ready`=0 in RUN and DONE. `in_valid` is ignored there, and `a`/`b` may change freely.
- `in_ready` is combinational from the state. `out_valid`, `diff` and `borrow_out` are registered or decoded from state, with no combinational path from `out_ready`.
- Arithmetic: unsigned operands; the result is exact modulo 2^WIDTH. `borrow_out` equals the final cell borrow, i.e. `a < b`.

## Timing
- Reset (`rst_n`=0, asynchronous) gives:
  - state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0;
  - `diff`=0, `borrow_out`=0;
  - counter and shift registers at 0.
- Latency: accept at edge 0, RUN bits processed at edges 1..WIDTH, `out_valid` high in the cycle after edge WIDTH.
- Throughput: at best one operation per WIDTH+2 cycles (accept, WIDTH bits, handshake).
- Back-pressure: DONE holds indefinitely while `out_ready`=0. Outputs do not change.
- `out_ready` held at 1 constantly: `out_valid` lasts exactly one cycle.
- Reset asserted mid-RUN or in DONE: the operation is abandoned, no result is produced, and all outputs take their reset values immediately.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_SAT_EN`.
- Defined: when the final borrow is 1, `diff` is forced to 0 in DONE, giving saturating unsigned subtraction. `borrow_out` still reports 1.
- Undefined: `diff` is the wrapped modulo-2^WIDTH result.
- Neither the port list nor the timing changes between the two builds.

## Structure
- Package `serial_subtractor_pkg`: the state enum (IDLE, RUN, DONE) and the default width constant `SUB_DEFAULT_WIDTH`=4.
- Sub-module `full_subtractor`: combinational one-bit cell with ports `a`, `b`, `bin`, `d`, `bout`. It is instantiated once.
- The FSM, counter (`$clog2(WIDTH)` bits) and shift registers live in the top module.

## Test plan
- WIDTH=4, a=9, b=3 → `out_valid` in the cycle after edge 4; `diff`=6, `borrow_out`=0.
- a=3, b=9:
  - default build → `diff`=4'hA, `borrow_out`=1;
  - with `SERIAL_SUBTRACTOR_SAT_EN` → `diff`=0, `borrow_out`=1.
- Corner operands:
  - a=0, b=15 → `diff`=1, `borrow_out`=1;
  - a=15, b=15 → `diff`=0, `borrow_out`=0;
  - a=0, b=0 → `diff`=0, `borrow_out`=0.
- Hold `out_ready`=0 for 5 cycles in DONE, toggling `in_valid`/`a`/`b` meanwhile → `diff` is stable, `in_ready`=0, no new accept. Then one `out_ready` pulse → IDLE and `in_ready`=1 the next cycle.
- Reset mid-RUN, after 2 bits → all outputs reach their reset values immediately. A fresh a=5, b=2 then gives `diff`=3.
- WIDTH=8, a=200, b=55 → `diff`=145, `borrow_out`=0, `out_valid` in the cycle after edge 8.
